// File: rtl/dac_wave_gen.sv
// Phase-accumulator waveform source for the DAC8830 driver: one scaled, offset
// and saturated 16-bit code plus a one-cycle update strobe per sample period.
module dac_wave_gen #(
  parameter int PHASE_W = 24,
  parameter int DIV_MIN = 40
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_wave,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [15:0]        cfg_div,
  input  logic [15:0]        cfg_amp,
  input  logic [15:0]        cfg_offset,
  output logic [15:0]        dac_data,
  output logic               dac_update,
  output logic               cfg_pending
);

  localparam logic [15:0] DIV_FLOOR = 16'(DIV_MIN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [1:0]         sh_wave, act_wave;
  logic [PHASE_W-1:0] sh_step, act_step;
  logic [15:0]        sh_div, act_div;
  logic [15:0]        sh_amp, act_amp;
  logic [15:0]        sh_offset, act_offset;

  logic [PHASE_W-1:0] phase;
  logic [15:0]        div_cnt;

  logic        s0_valid, s1_valid;
  logic [15:0] ph_s, amp_s, off_s, off_1;
  logic [1:0]  wave_s;
  logic [15:0] raw;
  logic [31:0] prod;
  logic [16:0] sum;

  logic tick, start, apply;

  assign tick  = (state == RUN) && (div_cnt == act_div);
  assign start = (state == IDLE) && enable;
  assign apply = cfg_pending && ((state == IDLE) || tick);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable)  state_next = RUN;
      RUN:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A load coinciding with an apply wins the pending flag: the apply moves the old shadow.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_wave     <= '0;
      sh_step     <= '0;
      sh_div      <= DIV_FLOOR;
      sh_amp      <= '0;
      sh_offset   <= '0;
      act_wave    <= '0;
      act_step    <= '0;
      act_div     <= DIV_FLOOR;
      act_amp     <= '0;
      act_offset  <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_load) begin
        sh_wave   <= cfg_wave;
        sh_step   <= cfg_step;
        sh_div    <= (cfg_div < DIV_FLOOR) ? DIV_FLOOR : cfg_div;
        sh_amp    <= cfg_amp;
        sh_offset <= cfg_offset;
      end
      if (apply) begin
        act_wave   <= sh_wave;
        act_step   <= sh_step;
        act_div    <= sh_div;
        act_amp    <= sh_amp;
        act_offset <= sh_offset;
      end
      if (cfg_load)   cfg_pending <= 1'b1;
      else if (apply) cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phase   <= '0;
      div_cnt <= '0;
    end else if (start) begin
      phase   <= '0;
      div_cnt <= '0;
    end else if (state == RUN) begin
      if (tick) begin
        phase   <= phase + act_step;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    raw = '0;
    case (wave_s)
      2'd0: raw = '0;
      2'd1: raw = ph_s;
      2'd2: raw = ph_s[15] ? {~ph_s[14:0], 1'b0} : {ph_s[14:0], 1'b0};
      2'd3: raw = ph_s[15] ? 16'hFFFF : 16'h0000;
      default: raw = '0;
    endcase
  end

  assign sum = 17'(prod >> 16) + 17'(off_1);

  // Gating every stage with enable flushes in-flight samples the moment enable drops.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      ph_s       <= '0;
      wave_s     <= '0;
      amp_s      <= '0;
      off_s      <= '0;
      off_1      <= '0;
      prod       <= '0;
      dac_data   <= '0;
      dac_update <= 1'b0;
    end else begin
      s0_valid   <= tick && enable;
      s1_valid   <= s0_valid && enable;
      dac_update <= s1_valid && enable;
      if (tick) begin
        ph_s   <= phase[PHASE_W-1 -: 16];
        wave_s <= act_wave;
        amp_s  <= act_amp;
        off_s  <= act_offset;
      end
      if (s0_valid) begin
        prod  <= 32'(raw) * 32'(amp_s);
        off_1 <= off_s;
      end
      if (s1_valid && enable)
        dac_data <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: table of configurations plus hand-written
// sequences for saw wrap, config boundary, disable and asynchronous reset.
module tb_dac_wave_gen;

  localparam int PHASE_W = 24;
  localparam int DIV_MIN = 40;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               enable;
  logic               cfg_load;
  logic [1:0]         cfg_wave;
  logic [PHASE_W-1:0] cfg_step;
  logic [15:0]        cfg_div;
  logic [15:0]        cfg_amp;
  logic [15:0]        cfg_offset;
  logic [15:0]        dac_data;
  logic               dac_update;
  logic               cfg_pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [1:0]   wave;
    logic [23:0]  step;
    logic [15:0]  div;
    logic [15:0]  amp;
    logic [15:0]  offset;
    int           exp_first;
    int           exp_period;
    logic [15:0]  exp_code0;
    logic [15:0]  exp_code1;
  } vec_t;

  vec_t vecs[5];

  dac_wave_gen #(.PHASE_W(PHASE_W), .DIV_MIN(DIV_MIN)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .cfg_load   (cfg_load),
    .cfg_wave   (cfg_wave),
    .cfg_step   (cfg_step),
    .cfg_div    (cfg_div),
    .cfg_amp    (cfg_amp),
    .cfg_offset (cfg_offset),
    .dac_data   (dac_data),
    .dac_update (dac_update),
    .cfg_pending(cfg_pending)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w, input logic [23:0] s, input logic [15:0] d,
                               input logic [15:0] a, input logic [15:0] o);
    @(negedge sys_clk);
    cfg_wave   = w;
    cfg_step   = s;
    cfg_div    = d;
    cfg_amp    = a;
    cfg_offset = o;
    cfg_load   = 1'b1;
    @(negedge sys_clk);
    cfg_load   = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    enable   = 1'b0;
    cfg_load = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst  = 1'b0;
  endtask

  // Returns once edge 0 (the one sampling enable=1) has passed.
  task automatic start_run();
    @(negedge sys_clk);
    enable = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (dac_update) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge sys_clk);
      #1;
      if (dac_update) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    int n;
    logic [15:0] held;
    longint p;

    vecs[0] = '{"dc",      2'd0, 24'h000000, 16'd99, 16'h1234, 16'h8000, 102, 100, 16'h8000, 16'h8000};
    vecs[1] = '{"square",  2'd3, 24'h800000, 16'd49, 16'hFFFF, 16'h4000,  52,  50, 16'h4000, 16'hFFFF};
    vecs[2] = '{"clamp",   2'd0, 24'h000000, 16'd5,  16'h0000, 16'h1111,  42,  40, 16'h1111, 16'h1111};
    vecs[3] = '{"tri",     2'd2, 24'h400000, 16'd60, 16'hFFFF, 16'h0100,  63,  61, 16'h0100, 16'h80FF};
    vecs[4] = '{"saw_amp", 2'd1, 24'h300000, 16'd45, 16'h4000, 16'h0010,  48,  46, 16'h0010, 16'h0C10};

    sys_rst    = 1'b1;
    enable     = 1'b0;
    cfg_load   = 1'b0;
    cfg_wave   = '0;
    cfg_step   = '0;
    cfg_div    = '0;
    cfg_amp    = '0;
    cfg_offset = '0;
    #1;
    checkOutput("reset_data",    32'(dac_data),    32'h0);
    checkOutput("reset_update",  32'(dac_update),  32'h0);
    checkOutput("reset_pending", 32'(cfg_pending), 32'h0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      applyStimulus(vecs[v].wave, vecs[v].step, vecs[v].div, vecs[v].amp, vecs[v].offset);
      checkOutput({vecs[v].name, "_pending"}, 32'(cfg_pending), 32'h1);
      start_run();
      wait_strobe(500, e);
      checkOutput({vecs[v].name, "_first_edge"}, 32'(e), 32'(vecs[v].exp_first));
      checkOutput({vecs[v].name, "_code0"}, 32'(dac_data), 32'(vecs[v].exp_code0));
      wait_strobe(500, e);
      checkOutput({vecs[v].name, "_period"}, 32'(e), 32'(vecs[v].exp_period));
      checkOutput({vecs[v].name, "_code1"}, 32'(dac_data), 32'(vecs[v].exp_code1));
    end

    // Saw wrap: top 16 phase bits step by 0x1000 and wrap after 16 samples.
    do_reset();
    applyStimulus(2'd1, 24'h100000, 16'd49, 16'hFFFF, 16'h0000);
    start_run();
    for (int k = 0; k <= 16; k++) begin
      wait_strobe(200, e);
      p = longint'(k % 16) * 4096;
      checkOutput($sformatf("saw_wrap_%0d", k), 32'(dac_data), 32'((p * 65535) >> 16));
    end

    // Offset change mid-period: old value in the next sample, new one after.
    do_reset();
    applyStimulus(2'd0, 24'h0, 16'd49, 16'h0000, 16'h1000);
    start_run();
    wait_strobe(200, e);
    repeat (10) @(posedge sys_clk);
    applyStimulus(2'd0, 24'h0, 16'd49, 16'h0000, 16'h2000);
    checkOutput("boundary_pending_set", 32'(cfg_pending), 32'h1);
    wait_strobe(200, e);
    checkOutput("boundary_old_offset", 32'(dac_data), 32'h1000);
    checkOutput("boundary_pending_clr", 32'(cfg_pending), 32'h0);
    wait_strobe(200, e);
    checkOutput("boundary_new_period", 32'(e), 32'd50);
    checkOutput("boundary_new_offset", 32'(dac_data), 32'h2000);

    // Drop enable so the edge after the next tick samples it low.
    held = dac_data;
    repeat (48) @(posedge sys_clk);
    @(negedge sys_clk);
    enable = 1'b0;
    count_strobes(100, n);
    checkOutput("disable_no_strobe", 32'(n), 32'd0);
    checkOutput("disable_data_hold", 32'(dac_data), 32'(held));

    // Asynchronous reset in the middle of a running, pending configuration.
    do_reset();
    applyStimulus(2'd0, 24'h0, 16'd49, 16'h0000, 16'h5555);
    start_run();
    wait_strobe(200, e);
    checkOutput("prereset_data", 32'(dac_data), 32'h5555);
    applyStimulus(2'd0, 24'h0, 16'd49, 16'h0000, 16'h7777);
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    enable  = 1'b0;
    #1;
    checkOutput("async_reset_data",    32'(dac_data),    32'h0);
    checkOutput("async_reset_update",  32'(dac_update),  32'h0);
    checkOutput("async_reset_pending", 32'(cfg_pending), 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    count_strobes(100, n);
    checkOutput("postreset_no_strobe", 32'(n), 32'd0);
    start_run();
    wait_strobe(200, e);
    checkOutput("postreset_first_edge", 32'(e), 32'd42);
    checkOutput("postreset_data", 32'(dac_data), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
